byte2bit: RTL

//  Byte-to-bit serializer feeding the LDPC encoder: the transmit-side counterpart of the

---
 rtl/byte2bit_pkg.sv | 23 ++
 rtl/byte2bit_fifo.sv | 62 ++++++
 rtl/byte2bit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/byte2bit_pkg.sv
// byte2bit_pkg: shared types and widths for the byte-to-bit serializer.
// FSM encodings, FIFO entry layout and a helper that builds an entry.
package byte2bit_pkg;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } state_t;

    localparam int BYTE_W  = 8;
    localparam int TAG_W   = 2;
    localparam int ENTRY_W = BYTE_W + TAG_W;

    // Entry layout is {win1, win0, data}; tags travel verbatim with the byte.
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [BYTE_W-1:0] data,
        input logic              win0,
        input logic              win1
    );
        return {win1, win0, data};
    endfunction

endpackage

// File: rtl/byte2bit_fifo.sv
// byte2bit_fifo: DEPTH-deep synchronous FIFO with a registered occupancy count.
// Read data is the head entry (show-ahead); full/empty come from the count so a
// pop in a cycle never frees a slot for a push in that same cycle.
module byte2bit_fifo
    import byte2bit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = ENTRY_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/byte2bit.sv
// byte2bit: byte-to-bit serializer in front of the LDPC encoder.
// Tagged bytes enter through a valid/ready port into a small FIFO; each encoder
// request emits one bit (LSB first) with the byte's window tags one cycle later.
// Handshake: a byte transfers on a clock edge where byte_sync & byte_rdy; the
// sender holds byte_sync/data/tags stable until then. byte_rdy never depends
// on byte_sync.
// Optional macro BYTE2BIT_UNDERRUN_EN adds sticky underrun flag and a
// saturating count of requests that could not be served.
module byte2bit
    import byte2bit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        byte_sync,
    input  logic [7:0]  byte_data,
    input  logic        byte_win0,
    input  logic        byte_win1,
    output logic        byte_rdy,
    input  logic        ldpc_bit_req,
    output logic        ldpc_en_in,
    output logic        ldpc_din,
    output logic        ts0_win,
    output logic        ts1_win,
    output logic        state_dbg
`ifdef BYTE2BIT_UNDERRUN_EN
    ,
    output logic        underrun,
    output logic [15:0] underrun_cnt
`endif
);

    state_t              state;
    state_t              state_n;
    logic [BYTE_W-1:0]   sr;
    logic [TAG_W-1:0]    tag;
    logic [2:0]          bit_cnt;
    logic [ENTRY_W-1:0]  fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                load;
    logic                emit;
    logic                clr_tags;

    // Ready is held low throughout reset, otherwise reflects the registered count.
    assign byte_rdy  = reset_n & ~fifo_full;
    assign push      = byte_sync & byte_rdy;
    assign state_dbg = state;

    byte2bit_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (pack_entry(byte_data, byte_win0, byte_win1)),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Next state and datapath controls: load when idle, emit on request, reload on last bit.
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        load     = 1'b0;
        emit     = 1'b0;
        clr_tags = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_n = ST_LOADED;
                end else begin
                    clr_tags = 1'b1;
                end
            end
            ST_LOADED: begin
                if (ldpc_bit_req) begin
                    emit = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        if (!fifo_empty) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else begin
                            state_n = ST_EMPTY;
                        end
                    end
                end
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    // Shift register, bit counter and registered outputs; a load overrides the counter step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr         <= '0;
            tag        <= '0;
            bit_cnt    <= '0;
            ldpc_en_in <= 1'b0;
            ldpc_din   <= 1'b0;
            ts0_win    <= 1'b0;
            ts1_win    <= 1'b0;
        end else begin
            ldpc_en_in <= emit;
            if (emit) begin
                ldpc_din <= sr[bit_cnt];
                ts0_win  <= tag[0];
                ts1_win  <= tag[1];
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (load) begin
                sr      <= fifo_dout[BYTE_W-1:0];
                tag     <= fifo_dout[ENTRY_W-1:BYTE_W];
                bit_cnt <= '0;
            end
            if (clr_tags) begin
                ts0_win <= 1'b0;
                ts1_win <= 1'b0;
            end
        end
    end

`ifdef BYTE2BIT_UNDERRUN_EN
    // Sticky flag and saturating count of requests arriving with nothing loaded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (ldpc_bit_req && (state == ST_EMPTY)) begin
            underrun <= 1'b1;
            if (underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
